// File: rtl/asteroid_motion.sv
// Multi-channel asteroid position engine: per-channel load in IDLE, and one
// motion step per channel swept sequentially after a tick, with selectable edge handling.
module asteroid_motion #(
  parameter int NUM_AST  = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPD_W    = 2,
  localparam int IDX_W   = $clog2(NUM_AST)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [X_W-1:0]   load_x,
  input  logic [Y_W-1:0]   load_y,
  input  logic [1:0]       load_dir,
  input  logic [SPD_W-1:0] load_spd,
  input  logic             tick,
  input  logic [1:0]       edge_mode,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic [1:0]       rd_dir,
  output logic             rd_alive,
  output logic             busy,
  output logic             done
);

  localparam logic [X_W:0]   LIM_X = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   LIM_Y = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W-1:0] MAX_X = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] MAX_Y = Y_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, FIN = 2'd2} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] sweep_idx_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [X_W-1:0]   x_reg     [NUM_AST];
  logic [Y_W-1:0]   y_reg     [NUM_AST];
  logic [1:0]       dir_reg   [NUM_AST];
  logic [SPD_W-1:0] spd_reg   [NUM_AST];
  logic             alive_reg [NUM_AST];

  logic [NUM_AST-1:0] ld_en;
  logic [NUM_AST-1:0] upd_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AST; gi++) begin : g_en
      assign ld_en[gi]  = (state_reg == IDLE) && load && (load_idx == IDX_W'(gi));
      assign upd_en[gi] = (state_reg == SWEEP) && (sweep_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Next-state of the channel currently addressed by the sweep
  logic [X_W-1:0]   cur_x, new_x, x_wrap, x_clamp;
  logic [Y_W-1:0]   cur_y, new_y, y_wrap, y_clamp;
  logic [1:0]       cur_dir, new_dir;
  logic [SPD_W-1:0] cur_spd;
  logic             cur_alive, new_alive;
  logic             is_x, neg, x_lo, x_hi, y_lo, y_hi, hit;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;

  always_comb begin
    cur_x     = x_reg[sweep_idx_reg];
    cur_y     = y_reg[sweep_idx_reg];
    cur_dir   = dir_reg[sweep_idx_reg];
    cur_spd   = spd_reg[sweep_idx_reg];
    cur_alive = alive_reg[sweep_idx_reg];
    is_x      = cur_dir[1];
    neg       = cur_dir[1] ^ cur_dir[0];

    sum_x = neg ? ({1'b0, cur_x} - (X_W+1)'(cur_spd)) : ({1'b0, cur_x} + (X_W+1)'(cur_spd));
    sum_y = neg ? ({1'b0, cur_y} - (Y_W+1)'(cur_spd)) : ({1'b0, cur_y} + (Y_W+1)'(cur_spd));

    // Top bit set means the signed sum went negative
    x_lo = sum_x[X_W];
    x_hi = !x_lo && (sum_x >= LIM_X);
    y_lo = sum_y[Y_W];
    y_hi = !y_lo && (sum_y >= LIM_Y);

    x_wrap  = x_lo ? X_W'(sum_x + LIM_X) : (x_hi ? X_W'(sum_x - LIM_X) : sum_x[X_W-1:0]);
    y_wrap  = y_lo ? Y_W'(sum_y + LIM_Y) : (y_hi ? Y_W'(sum_y - LIM_Y) : sum_y[Y_W-1:0]);
    x_clamp = x_lo ? '0 : (x_hi ? MAX_X : sum_x[X_W-1:0]);
    y_clamp = y_lo ? '0 : (y_hi ? MAX_Y : sum_y[Y_W-1:0]);
    hit     = is_x ? (x_lo || x_hi) : (y_lo || y_hi);

    new_x     = cur_x;
    new_y     = cur_y;
    new_dir   = cur_dir;
    new_alive = cur_alive;

    if (cur_alive && (cur_spd != '0)) begin
      case (edge_mode)
        2'b00: begin
          if (is_x) new_x = x_wrap;
          else      new_y = y_wrap;
        end
        2'b01, 2'b10: begin
          if (is_x) new_x = x_clamp;
          else      new_y = y_clamp;
          if (edge_mode == 2'b10 && hit) new_dir = {cur_dir[1], ~cur_dir[0]};
        end
        default: begin
          if (hit)       new_alive = 1'b0;
          else if (is_x) new_x = sum_x[X_W-1:0];
          else           new_y = sum_y[Y_W-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_AST; i++) begin
      if (!resetn) begin
        x_reg[i]     <= '0;
        y_reg[i]     <= '0;
        dir_reg[i]   <= 2'b00;
        spd_reg[i]   <= '0;
        alive_reg[i] <= 1'b0;
      end else if (ld_en[i]) begin
        x_reg[i]     <= load_x;
        y_reg[i]     <= load_y;
        dir_reg[i]   <= load_dir;
        spd_reg[i]   <= load_spd;
        alive_reg[i] <= 1'b1;
      end else if (upd_en[i]) begin
        x_reg[i]     <= new_x;
        y_reg[i]     <= new_y;
        dir_reg[i]   <= new_dir;
        alive_reg[i] <= new_alive;
      end
    end
  end

  // Sweep controller; a load arriving with a tick takes precedence
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      sweep_idx_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tick && !load) begin
            state_reg     <= SWEEP;
            sweep_idx_reg <= '0;
            busy_reg      <= 1'b1;
          end
        end
        SWEEP: begin
          if (sweep_idx_reg == IDX_W'(NUM_AST - 1)) begin
            state_reg <= FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            sweep_idx_reg <= sweep_idx_reg + 1'b1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_x     = '0;
    rd_y     = '0;
    rd_dir   = 2'b00;
    rd_alive = 1'b0;
    if (int'(rd_idx) < NUM_AST) begin
      rd_x     = x_reg[rd_idx];
      rd_y     = y_reg[rd_idx];
      rd_dir   = dir_reg[rd_idx];
      rd_alive = alive_reg[rd_idx];
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_asteroid_motion.sv
// Scoreboard bench for asteroid_motion: stimulus queues expected channel state,
// a monitor pops and compares on each done pulse (or immediately for idle probes).
module tb_asteroid_motion;

  localparam int NUM_AST = 4;
  localparam int IDX_W   = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic [7:0]       load_x;
  logic [6:0]       load_y;
  logic [1:0]       load_dir;
  logic [1:0]       load_spd;
  logic             tick;
  logic [1:0]       edge_mode;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_x;
  logic [6:0]       rd_y;
  logic [1:0]       rd_dir;
  logic             rd_alive;
  logic             busy;
  logic             done;

  asteroid_motion dut (
    .clk(clk), .resetn(resetn), .load(load), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y), .load_dir(load_dir), .load_spd(load_spd),
    .tick(tick), .edge_mode(edge_mode), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .rd_dir(rd_dir), .rd_alive(rd_alive),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit on_done;
    int idx;
    int x;
    int y;
    int dir;
    int alive;
    int exp_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void push(input bit od, input int idx, input int x, input int y,
                               input int dir, input int alive, input int ec);
    exp_t e;
    e.on_done = od; e.idx = idx; e.x = x; e.y = y; e.dir = dir; e.alive = alive; e.exp_cyc = ec;
    exp_q.push_back(e);
  endfunction

  // Monitor: sole driver of rd_idx
  initial begin
    exp_t e;
    logic d;
    int   n;
    rd_idx = '0;
    forever begin
      @(negedge clk);
      d = done;
      if (busy) busy_cnt++;
      if (d) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0 || !exp_q[0].on_done) begin
          errors++;
          $display("FAIL done_pulse actual=1 expected=0 at cycle %0d", cyc);
        end
      end
      n = 0;
      while (exp_q.size() > 0 && n < 4 && (!exp_q[0].on_done || d)) begin
        e = exp_q.pop_front();
        n++;
        if (e.exp_cyc >= 0) chk("done_latency", cyc, e.exp_cyc);
        rd_idx = IDX_W'(e.idx);
        #1;
        chk($sformatf("ch%0d_x", e.idx), int'(rd_x), e.x);
        chk($sformatf("ch%0d_y", e.idx), int'(rd_y), e.y);
        chk($sformatf("ch%0d_dir", e.idx), int'(rd_dir), e.dir);
        chk($sformatf("ch%0d_alive", e.idx), int'(rd_alive), e.alive);
        $display("txn ch%0d x=%0d y=%0d dir=%0d alive=%0d", e.idx, rd_x, rd_y, rd_dir, rd_alive);
      end
    end
  end

  task automatic do_load(input int idx, input int x, input int y, input int dir, input int spd);
    @(posedge clk); #1;
    load = 1'b1; load_idx = IDX_W'(idx); load_x = 8'(x); load_y = 7'(y);
    load_dir = 2'(dir); load_spd = 2'(spd);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Returns the cycle count right after the edge that accepted the tick
  task automatic do_tick(output int acc);
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, bc, dc;
    resetn = 1'b0; load = 1'b0; tick = 1'b0; edge_mode = 2'b00;
    load_idx = '0; load_x = '0; load_y = '0; load_dir = '0; load_spd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    resetn = 1'b1;
    for (int i = 0; i < NUM_AST; i++) push(1'b0, i, 0, 0, 0, 0, -1);
    wait_drain();

    // Wrap on +x: 158+3 -> 1
    do_load(0, 158, 10, 3, 3);
    edge_mode = 2'b00;
    do_tick(acc);
    push(1'b1, 0, 1, 10, 3, 1, acc + NUM_AST);
    push(1'b1, 1, 0, 0, 0, 0, -1);
    wait_drain();

    // Bounce on -y: 1-2 -> 0 with dir flip, then back up
    do_load(1, 5, 1, 1, 2);
    edge_mode = 2'b10;
    do_tick(acc);
    push(1'b1, 1, 5, 0, 0, 1, acc + NUM_AST);
    push(1'b1, 0, 4, 10, 3, 1, -1);
    wait_drain();
    do_tick(acc);
    push(1'b1, 1, 5, 2, 0, 1, acc + NUM_AST);
    push(1'b1, 0, 7, 10, 3, 1, -1);
    wait_drain();

    // Clamp at bottom, then despawn, then no further change
    do_load(2, 2, 119, 0, 1);
    edge_mode = 2'b01;
    do_tick(acc);
    push(1'b1, 2, 2, 119, 0, 1, acc + NUM_AST);
    push(1'b1, 0, 10, 10, 3, 1, -1);
    push(1'b1, 1, 5, 4, 0, 1, -1);
    wait_drain();
    edge_mode = 2'b11;
    do_tick(acc);
    push(1'b1, 2, 2, 119, 0, 0, acc + NUM_AST);
    push(1'b1, 0, 13, 10, 3, 1, -1);
    push(1'b1, 1, 5, 6, 0, 1, -1);
    wait_drain();
    do_tick(acc);
    push(1'b1, 2, 2, 119, 0, 0, acc + NUM_AST);
    push(1'b1, 0, 16, 10, 3, 1, -1);
    push(1'b1, 1, 5, 8, 0, 1, -1);
    wait_drain();

    // Load and tick during a sweep are ignored
    do_load(3, 100, 50, 2, 1);
    edge_mode = 2'b00;
    bc = busy_cnt; dc = done_cnt;
    do_tick(acc);
    push(1'b1, 0, 19, 10, 3, 1, acc + NUM_AST);
    push(1'b1, 1, 5, 10, 0, 1, -1);
    push(1'b1, 2, 2, 119, 0, 0, -1);
    push(1'b1, 3, 99, 50, 2, 1, -1);
    @(posedge clk); #1;
    load = 1'b1; tick = 1'b1; load_idx = 2'd0; load_x = 8'd50; load_y = 7'd50;
    load_dir = 2'd0; load_spd = 2'd3;
    @(posedge clk); #1;
    load = 1'b0; tick = 1'b0;
    wait_drain();
    chk("busy_cycles_sweep", busy_cnt - bc, 4);
    chk("done_pulses_sweep", done_cnt - dc, 1);

    // Load wins over a simultaneous tick
    bc = busy_cnt; dc = done_cnt;
    @(posedge clk); #1;
    load = 1'b1; tick = 1'b1; load_idx = 2'd3; load_x = 8'd20; load_y = 7'd30;
    load_dir = 2'd1; load_spd = 2'd2;
    @(posedge clk); #1;
    load = 1'b0; tick = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("busy_cycles_loadtick", busy_cnt - bc, 0);
    chk("done_pulses_loadtick", done_cnt - dc, 0);
    push(1'b0, 3, 20, 30, 1, 1, -1);
    push(1'b0, 0, 19, 10, 3, 1, -1);
    wait_drain();

    // Reset mid-sweep aborts with no done pulse
    bc = busy_cnt; dc = done_cnt;
    do_tick(acc);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_busy_cycles", busy_cnt - bc, 2);
    chk("abort_done_pulses", done_cnt - dc, 0);
    for (int i = 0; i < NUM_AST; i++) push(1'b0, i, 0, 0, 0, 0, -1);
    wait_drain();

    // Normal operation resumes after the abort
    do_load(0, 10, 10, 3, 1);
    do_tick(acc);
    push(1'b1, 0, 11, 10, 3, 1, acc + NUM_AST);
    push(1'b1, 1, 0, 0, 0, 0, -1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/asteroid_motion.md
ASTEROID_MOTION -- requirements
Module: asteroid_motion

Interface
REQ-001 Parameter NUM_AST, default 4: number of independent asteroid channels (2..16).
REQ-002 Parameter X_W, default 8: x coordinate width.
REQ-003 Parameter Y_W, default 7: y coordinate width.
REQ-004 Parameter SCREEN_W, default 160: valid x range 0..SCREEN_W-1.
REQ-005 Parameter SCREEN_H, default 120: valid y range 0..SCREEN_H-1.
REQ-006 Parameter SPD_W, default 2: speed width; max speed SHALL be less than SCREEN_W and SCREEN_H.
REQ-007 IDX_W is a local parameter equal to clog2(NUM_AST).
REQ-008 clk  in  1  single clock; all state updates on its rising edge.
REQ-009 resetn  in  1  synchronous, active-low reset.
REQ-010 load  in  1  write one channel's state in this cycle.
REQ-011 load_idx  in  IDX_W  channel to write.
REQ-012 load_x / load_y  in  X_W / Y_W  start position.
REQ-013 load_dir  in  2  direction: 00 +y, 01 -y, 11 +x, 10 -x.
REQ-014 load_spd  in  SPD_W  pixels moved per step.
REQ-015 tick  in  1  request one motion step of all channels.
REQ-016 edge_mode  in  2  00 wrap, 01 clamp, 10 bounce, 11 despawn.
REQ-017 rd_idx  in  IDX_W  channel selected for readback.
REQ-018 rd_x / rd_y / rd_dir / rd_alive  out  X_W / Y_W / 2 / 1  combinational view of the selected channel's registers.
REQ-019 busy  out  1  high while a step sweep is in progress.
REQ-020 done  out  1  one-cycle pulse when a sweep completes.

Function
REQ-021 FSM states SHALL be IDLE, SWEEP and FIN.
REQ-022 IDLE with tick=1 and load=0 SHALL go to SWEEP with the sweep index at 0 and busy=1 from the next cycle.
REQ-023 SWEEP SHALL update exactly one channel per cycle, in ascending index order 0..NUM_AST-1.
REQ-024 After channel NUM_AST-1 is updated, the FSM SHALL go to FIN; FIN SHALL assert done=1, busy=0 for one cycle, then return to IDLE.
REQ-025 Latency SHALL be tick accepted at cycle T -> done high at cycle T+NUM_AST+1.
REQ-026 load in IDLE SHALL write x, y, dir and spd of load_idx and set its alive flag to 1 at the next edge.
REQ-027 load and tick high together in IDLE: the load SHALL win and the tick SHALL be dropped.
REQ-028 load or tick while busy, or during FIN, SHALL be ignored with no side effects.
REQ-029 edge_mode SHALL be sampled per channel update, not latched per sweep.
REQ-030 A channel with alive=0 or spd=0 SHALL keep its state unchanged during its update.
REQ-031 Next position SHALL be computed one bit wider than the coordinate, signed: p' = p +/- spd on the axis selected by dir; the other axis SHALL be unchanged.
REQ-032 Wrap: p'<0 -> p'+LIMIT; p'>=LIMIT -> p'-LIMIT, where LIMIT is SCREEN_W for x and SCREEN_H for y.
REQ-033 Clamp: p'<0 -> 0; p'>=LIMIT -> LIMIT-1; dir unchanged.
REQ-034 Bounce: clamp as REQ-033, and on any limit hit dir SHALL flip (00<->01, 11<->10) in the same update.
REQ-035 Despawn: if p' is out of range, alive SHALL be cleared and the position held; otherwise p' is stored.
REQ-036 Landing exactly on 0 or LIMIT-1 SHALL NOT count as a limit hit.
REQ-037 Loaded positions outside the screen SHALL be stored as given; the first update SHALL apply the edge rule to the resulting p'.

Reset
REQ-038 resetn=0 at an edge SHALL clear all channels to x=0, y=0, dir=00, spd=0, alive=0; set busy=0 and done=0; and force IDLE.
REQ-039 Reset during SWEEP or FIN SHALL abort the sweep with no done pulse; reset SHALL take priority over load and tick.

Verification
REQ-040 Load ch0 (x=158, y=10, dir=11, spd=3), wrap, tick -> after done, rd x=1, y=10, alive=1; done at tick+5 cycles for NUM_AST=4.
REQ-041 Load ch1 (x=5, y=1, dir=01, spd=2), bounce, tick -> y=0 and dir=00; second tick -> y=2.
REQ-042 Load ch2 (x=2, y=119, dir=00, spd=1), clamp, tick -> y=119; despawn, tick -> alive=0, y=119; further ticks -> no change.
REQ-043 Tick issued and then load at cycle T+2 -> load ignored, busy high for 4 cycles, single done pulse; channels 0..3 each moved exactly once.
REQ-044 Load and tick together in IDLE -> channel written, busy stays 0, no done pulse.
REQ-045 resetn low for one cycle mid-SWEEP -> busy=0, done never asserted, all rd_* for every index read 0 and IDLE state resumes.
